// File: rtl/instr_fetch_unit.sv
// KGP-miniRISC instruction fetch unit.
// Holds the PC and sequences one-word fetches from a synchronous instruction memory.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_AW     = 10,
  parameter int          MEM_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc_new,
  input  logic               pc_update,
  input  logic               halt,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic               halted,
  output logic               misaligned,
  output logic [31:0]        instr_count
);

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    HOLD,
    HALTED,
    ERR
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  cnt;
  logic [1:0]  cnt_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] count_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      cnt         <= 2'd0;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = pc;
    instr_nxt = instr;
    count_nxt = instr_count;
    unique case (state)
      REQ: begin
        cnt_nxt   = LAT_M1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          instr_nxt = imem_rdata;
          count_nxt = instr_count + 32'd1;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      HOLD: begin
        // halt wins; a same-cycle pc_new is dropped
        if (halt) begin
          state_nxt = HALTED;
        end else if (pc_update) begin
          pc_nxt    = pc_new;
          state_nxt = (pc_new[1:0] != 2'b00) ? ERR : REQ;
        end
      end
      HALTED: state_nxt = HALTED;
      ERR:    state_nxt = ERR;
      default: state_nxt = REQ;
    endcase
  end

  // Gate with rst so the reset cycle never issues a read
  assign imem_en     = (state == REQ) && !rst;
  assign imem_addr   = pc[IMEM_AW+1:2];
  assign instr_valid = (state == HOLD);
  assign halted      = (state == HALTED);
  assign misaligned  = (state == ERR);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (latency 1 and 3).
// Fetch results are checked by scoreboards on each instr_valid rise.
module tb_instr_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];

  logic        rst1, upd1, halt1;
  logic [31:0] pcn1, rdata1, pc1, instr1, cnt1;
  logic        en1, v1, hlt1, mis1;
  logic [9:0]  addr1;

  logic        rst3, upd3, halt3;
  logic [31:0] pcn3, rdata3, pc3, instr3, cnt3;
  logic        en3, v3, hlt3, mis3;
  logic [9:0]  addr3;

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000), .IMEM_AW(10), .MEM_LATENCY(1)
  ) dut1 (
    .clk(clk), .rst(rst1), .pc_new(pcn1), .pc_update(upd1),
    .halt(halt1), .imem_rdata(rdata1), .pc(pc1), .imem_en(en1),
    .imem_addr(addr1), .instr(instr1), .instr_valid(v1),
    .halted(hlt1), .misaligned(mis1), .instr_count(cnt1)
  );

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0200), .IMEM_AW(10), .MEM_LATENCY(3)
  ) dut3 (
    .clk(clk), .rst(rst3), .pc_new(pcn3), .pc_update(upd3),
    .halt(halt3), .imem_rdata(rdata3), .pc(pc3), .imem_en(en3),
    .imem_addr(addr3), .instr(instr3), .instr_valid(v3),
    .halted(hlt3), .misaligned(mis3), .instr_count(cnt3)
  );

  // Memory models: garbage on idle cycles so a mistimed latch is visible
  logic [31:0] p1;
  logic [31:0] p3 [0:2];
  always @(posedge clk) begin
    p1    <= en1 ? mem[addr1] : 32'hBAD0_0001;
    p3[0] <= en3 ? mem[addr3] : 32'hBAD0_0003;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rdata1 = p1;
  assign rdata3 = p3[2];

  exp_t q1 [$];
  exp_t q3 [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] p, input logic [31:0] i,
                              input logic [31:0] c);
    exp_t e;
    e.pc = p;
    e.instr = i;
    e.cnt = c;
    return e;
  endfunction

  logic pv1 = 1'b0;
  logic pv3 = 1'b0;
  always @(negedge clk) begin
    if (v1 === 1'b1 && pv1 !== 1'b1) begin
      if (q1.size() == 0) begin
        chk("sb1_unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("sb1_pc", pc1, e.pc);
        chk("sb1_instr", instr1, e.instr);
        chk("sb1_count", cnt1, e.cnt);
      end
    end
    if (v3 === 1'b1 && pv3 !== 1'b1) begin
      if (q3.size() == 0) begin
        chk("sb3_unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("sb3_pc", pc3, e.pc);
        chk("sb3_instr", instr3, e.instr);
        chk("sb3_count", cnt3, e.cnt);
      end
    end
    pv1 = v1;
    pv3 = v3;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_v1(input int budget);
    int n;
    n = 0;
    while (v1 !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("v1_timeout", {31'd0, v1}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[0] = 32'h1234_5678;
    rst1 = 1; upd1 = 0; halt1 = 0; pcn1 = 0;
    rst3 = 1; upd3 = 0; halt3 = 0; pcn3 = 0;

    // Reset and first fetch
    tick(); tick();
    chk("rst_pc", pc1, 32'h0);
    chk("rst_en", {31'd0, en1}, 32'd0);
    chk("rst_valid", {31'd0, v1}, 32'd0);
    chk("rst_count", cnt1, 32'd0);
    q1.push_back(mk(32'h0, 32'h1234_5678, 32'd1));
    rst1 = 0;
    #1;
    chk("req_en", {31'd0, en1}, 32'd1);
    chk("req_addr", {22'd0, addr1}, 32'd0);
    tick();
    chk("wait_en", {31'd0, en1}, 32'd0);
    chk("wait_valid", {31'd0, v1}, 32'd0);
    tick();
    chk("first_valid", {31'd0, v1}, 32'd1);

    // Sequential then branch commit
    pcn1 = 32'h4; upd1 = 1;
    q1.push_back(mk(32'h4, 32'hC0DE_0001, 32'd2));
    tick();
    upd1 = 0;
    chk("seq_addr", {22'd0, addr1}, 32'd1);
    chk("seq_en", {31'd0, en1}, 32'd1);
    wait_v1(6);
    pcn1 = 32'h100; upd1 = 1;
    q1.push_back(mk(32'h100, 32'hC0DE_0040, 32'd3));
    tick();
    upd1 = 0;
    chk("br_addr", {22'd0, addr1}, 32'd64);
    wait_v1(6);
    chk("count3", cnt1, 32'd3);

    // Misaligned commit
    pcn1 = 32'h102; upd1 = 1;
    tick();
    upd1 = 0;
    chk("mis_flag", {31'd0, mis1}, 32'd1);
    chk("mis_pc", pc1, 32'h102);
    chk("mis_valid", {31'd0, v1}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("mis_no_fetch", {31'd0, en1}, 32'd0);
      tick();
    end
    chk("mis_stuck", {31'd0, mis1}, 32'd1);

    // Halt priority over pc_update
    rst1 = 1; tick(); rst1 = 0;
    q1.push_back(mk(32'h0, 32'h1234_5678, 32'd1));
    wait_v1(6);
    halt1 = 1; upd1 = 1; pcn1 = 32'h8;
    tick();
    halt1 = 0;
    chk("halt_flag", {31'd0, hlt1}, 32'd1);
    chk("halt_pc", pc1, 32'h0);
    chk("halt_valid", {31'd0, v1}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("halt_no_fetch", {31'd0, en1}, 32'd0);
      tick();
    end
    upd1 = 0;
    chk("halt_pc_frozen", pc1, 32'h0);
    rst1 = 1; tick();
    chk("halt_rst_pc", pc1, 32'h0);
    chk("halt_rst_flag", {31'd0, hlt1}, 32'd0);
    rst1 = 0;

    // Reset mid-WAIT discards the read
    tick();
    chk("w_state_en", {31'd0, en1}, 32'd0);
    rst1 = 1; tick(); rst1 = 0;
    #1;
    chk("wrst_valid", {31'd0, v1}, 32'd0);
    chk("wrst_en", {31'd0, en1}, 32'd1);
    chk("wrst_addr", {22'd0, addr1}, 32'd0);
    chk("wrst_count", cnt1, 32'd0);
    q1.push_back(mk(32'h0, 32'h1234_5678, 32'd1));
    wait_v1(6);

    // Address wrap
    pcn1 = 32'h1004; upd1 = 1;
    q1.push_back(mk(32'h1004, 32'hC0DE_0001, 32'd2));
    tick();
    upd1 = 0;
    chk("wrap_addr", {22'd0, addr1}, 32'd1);
    chk("wrap_pc", pc1, 32'h1004);
    wait_v1(6);

    // Latency 3 with ignored update/halt during WAIT
    rst3 = 0;
    q3.push_back(mk(32'h200, 32'hC0DE_0080, 32'd1));
    #1;
    chk("l3_en", {31'd0, en3}, 32'd1);
    chk("l3_addr", {22'd0, addr3}, 32'h80);
    tick();
    upd3 = 1; pcn3 = 32'h40; halt3 = 1;
    tick();
    upd3 = 0; halt3 = 0;
    chk("l3_pc_kept", pc3, 32'h200);
    chk("l3_c2_valid", {31'd0, v3}, 32'd0);
    tick();
    chk("l3_c3_valid", {31'd0, v3}, 32'd0);
    tick();
    chk("l3_c4_valid", {31'd0, v3}, 32'd1);
    chk("l3_not_halted", {31'd0, hlt3}, 32'd0);
    chk("l3_pc", pc3, 32'h200);

    tick(); tick();
    chk("q1_drained", q1.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for KGP-miniRISC.
- Holds the architectural PC and drives it to branch control (its `pc` input).
- Fetches the instruction word at PC from a synchronous instruction memory and presents it to decode.
- Commits the next PC (branch control's `pc_new`) when the core signals end of execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 10, instruction-memory word-address width (depth = 2^IMEM_AW words).
- MEM_LATENCY, 1, cycles from the registered memory address to valid `imem_rdata`. Legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_new  input  32  next PC from branch control.
- pc_update  input  1  core pulse: execute done, commit `pc_new`.
- halt  input  1  stop fetching; sampled in HOLD only.
- imem_rdata  input  32  instruction memory read data.
- pc  output  32  current architectural PC.
- imem_en  output  1  instruction memory read enable.
- imem_addr  output  IMEM_AW  word address, equal to `pc[IMEM_AW+1:2]`.
- instr  output  32  latched instruction word.
- instr_valid  output  1  `instr` is valid for the current `pc`.
- halted  output  1  fetch stopped by halt.
- misaligned  output  1  committed `pc_new` had `[1:0] != 0`.
- instr_count  output  32  number of instructions issued since reset.

Behaviour:
- Clock and reset: one clock, `clk`. `rst` is synchronous and active-high; all state is updated on the rising edge of `clk`.
- Reset values:
  - `pc` = RESET_PC; state = REQ.
  - `instr` = 0; `instr_valid` = 0; `imem_en` = 0.
  - `halted` = 0; `misaligned` = 0; `instr_count` = 0.
- Reset mid-operation: any state, including HALTED and ERR, returns to the reset values at the next edge. An in-flight memory read is discarded.
- FSM states: REQ, WAIT, HOLD, HALTED, ERR.
- REQ (1 cycle):
  - `imem_en` = 1, `imem_addr` = `pc[IMEM_AW+1:2]`.
  - Go to WAIT and load the latency counter with MEM_LATENCY-1.
- WAIT (MEM_LATENCY cycles):
  - `imem_en` = 0; the counter decrements each cycle.
  - When counter == 0: `instr` <= `imem_rdata`, `instr_count` += 1, go to HOLD.
- HOLD:
  - `instr_valid` = 1 and `instr` is stable.
  - If `halt` = 1: go to HALTED. `halt` has priority over a same-cycle `pc_update`, and that `pc_new` is dropped.
  - Else if `pc_update` = 1: `pc` <= `pc_new`. If `pc_new[1:0] != 0`, go to ERR; otherwise go to REQ.
  - Else remain in HOLD.
- HALTED: `halted` = 1, `instr_valid` = 0, `pc` frozen. Exit only via `rst`.
- ERR: `misaligned` = 1, `instr_valid` = 0, no fetch issued, `pc` holds the misaligned value. Exit only via `rst`.
- `instr_valid` is 0 in every state other than HOLD.
- `pc_update` and `halt` outside HOLD are ignored: no PC change, no state change.
- Latency: from REQ entry to `instr_valid` = 1 is MEM_LATENCY+1 cycles. With MEM_LATENCY=1, a back-to-back loop is 3 cycles per instruction (REQ, WAIT, HOLD with `pc_update`).
- Address wrap: PC bits above IMEM_AW+1 are not used for addressing, so the memory index wraps. `pc` itself stays the full 32-bit value.
- `instr_count` wraps modulo 2^32.
- `pc` changes only in HOLD on an accepted `pc_update`, or on reset.

Test Plan:
1. Reset and first fetch: assert `rst` for 2 cycles, release, memory word 0 = 32'h1234_5678, MEM_LATENCY=1 → `imem_en` = 1 in the first cycle with `imem_addr` = 0; `instr_valid` = 1 two cycles later with `instr` = 32'h1234_5678, `pc` = 0, `instr_count` = 1.
2. Sequential and branch commits: in HOLD pulse `pc_update` with `pc_new` = 4, then with `pc_new` = 32'h0000_0100 → `imem_addr` = 1, then `imem_addr` = 64; `instr` matches memory each time; `instr_count` = 3.
3. Misaligned commit: `pc_update` with `pc_new` = 32'h0000_0102 → `misaligned` = 1 next cycle, `pc` = 32'h102, `instr_valid` = 0, `imem_en` remains 0 for 10 cycles.
4. Halt priority: `halt` and `pc_update` (`pc_new` = 8) asserted in the same HOLD cycle → `halted` = 1, `pc` unchanged, no further `imem_en`. Then `rst` → `pc` = RESET_PC, `halted` = 0.
5. Ignored update and latency: MEM_LATENCY=3; pulse `pc_update` with `pc_new` = 32'h40 during WAIT → `pc` unchanged; `instr_valid` rises exactly 4 cycles after REQ entry.
6. Reset mid-WAIT and wrap: assert `rst` during WAIT → `instr_valid` stays 0 and the fetch restarts at RESET_PC. Separately, commit `pc_new` = 32'h0000_1004 with IMEM_AW=10 → `imem_addr` = 1.
